// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the 8-bit XNOR LFSR generator and checker.
//   - lfsr_state_e : checker FSM states (HUNT, VERIFY, LOCKED)
//   - TAP_MASK     : taps 8,6,5,4 of r[8:1], packed as r[8] at bit 7
//   - lfsr_fb()    : XNOR feedback bit for a given register value
package lfsr_pkg;

   localparam logic [7:0] TAP_MASK = 8'hB8;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } lfsr_state_e;

   // XNOR of the tapped bits; the all-ones register value yields 1 (lockup state).
   function automatic logic lfsr_fb(input logic [7:0] r);
      return ~(^(r & TAP_MASK));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
// Ports:
//   clk   in  1  rising-edge clock
//   rst_n in  1  asynchronous active-low reset (q -> 0)
//   inc   in  1  increment by one unless already saturated
//   clr   in  1  synchronous clear, priority over inc
//   q     out W  current count
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: serial checker for the 8-bit XNOR LFSR feedback-bit stream.
// Loads 8 bits (HUNT), verifies LOCK_CNT consecutive predictions (VERIFY), then
// flywheels on its own predictions and counts mismatches (LOCKED). LOSS_CNT
// consecutive mismatches in LOCKED drop back to HUNT.
// Optional feature macro: LFSR_CHK_LOCKUP_DET_EN adds a sticky 'lockup' output that
// flags the all-ones register state and forces HUNT.
// Ports:
//   clk        in  1      rising-edge clock
//   rst_n      in  1      asynchronous active-low reset
//   bit_valid  in  1      bit_in is consumed when 1
//   bit_in     in  1      received stream bit
//   clear      in  1      sync: err_count=0, FSM=HUNT (drops a coincident bit)
//   locked     out 1      FSM is in LOCKED
//   err_pulse  out 1      one-cycle pulse per mismatch seen in LOCKED
//   err_count  out CNT_W  saturating mismatch count
//   lockup     out 1      (macro only) sticky all-ones detection
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int unsigned NUM_BITS = 8,
   parameter int unsigned LOCK_CNT = 16,
   parameter int unsigned LOSS_CNT = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
`ifdef LFSR_CHK_LOCKUP_DET_EN
   output logic             lockup,
`endif
   output logic [CNT_W-1:0] err_count
);

   localparam logic [3:0] FillLast = 4'(NUM_BITS - 1);
   localparam logic [7:0] LockLast = 8'(LOCK_CNT - 1);
   localparam logic [3:0] LossLast = 4'(LOSS_CNT - 1);

   lfsr_state_e         state_q, state_d;
   logic [NUM_BITS-1:0] shift_q, shift_d;
   logic [3:0]          fill_q, fill_d;
   logic [7:0]          match_q, match_d;
   logic [3:0]          miss_q, miss_d;
   logic                err_pulse_q, err_inc;
   logic                pred;

`ifdef LFSR_CHK_LOCKUP_DET_EN
   logic                lockup_q, lockup_d;
`endif

   assign pred = lfsr_fb(shift_q);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      fill_d  = fill_q;
      match_d = match_q;
      miss_d  = miss_q;
      err_inc = 1'b0;
`ifdef LFSR_CHK_LOCKUP_DET_EN
      lockup_d = lockup_q;
`endif
      if (clear) begin
         state_d = HUNT;
         fill_d  = '0;
         match_d = '0;
         miss_d  = '0;
`ifdef LFSR_CHK_LOCKUP_DET_EN
         lockup_d = 1'b0;
`endif
      end else if (bit_valid) begin
         case (state_q)
            HUNT: begin
               shift_d = {shift_q[NUM_BITS-2:0], bit_in};
               fill_d  = fill_q + 4'd1;
               if (fill_q == FillLast) begin
                  state_d = VERIFY;
                  match_d = '0;
               end
            end
            VERIFY: begin
               shift_d = {shift_q[NUM_BITS-2:0], bit_in};
               if (bit_in == pred) begin
                  match_d = match_q + 8'd1;
                  if (match_q == LockLast) begin
                     state_d = LOCKED;
                     miss_d  = '0;
                  end
               end else begin
                  match_d = '0;
               end
            end
            LOCKED: begin
               // Flywheel: the register follows its own prediction, not the line.
               shift_d = {shift_q[NUM_BITS-2:0], pred};
               if (bit_in != pred) begin
                  err_inc = 1'b1;
                  if (miss_q == LossLast) begin
                     state_d = HUNT;
                     fill_d  = '0;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss_q + 4'd1;
                  end
               end else begin
                  miss_d = '0;
               end
            end
            default: begin
               state_d = HUNT;
               fill_d  = '0;
            end
         endcase
`ifdef LFSR_CHK_LOCKUP_DET_EN
         // All-ones is a fixed point of the XNOR LFSR; checked on the bit that
         // completes the HUNT fill as well as every VERIFY/LOCKED shift.
         if (((state_q == VERIFY) || (state_q == LOCKED) ||
              ((state_q == HUNT) && (fill_q == FillLast))) &&
             (shift_d == {NUM_BITS{1'b1}})) begin
            state_d  = HUNT;
            fill_d   = '0;
            match_d  = '0;
            miss_d   = '0;
            lockup_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= HUNT;
         shift_q     <= '0;
         fill_q      <= '0;
         match_q     <= '0;
         miss_q      <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         miss_q      <= miss_d;
         err_pulse_q <= err_inc;
      end
   end

`ifdef LFSR_CHK_LOCKUP_DET_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lockup_q <= 1'b0;
      end else begin
         lockup_q <= lockup_d;
      end
   end

   assign lockup = lockup_q;
`endif

   sat_counter #(
      .W (CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (err_inc),
      .clr   (clear),
      .q     (err_count)
   );

   assign locked    = (state_q == LOCKED);
   assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed scenarios plus a randomized soak of lfsr_checker, checked
// every cycle against a behavioural model built on a bit-history queue, with literal
// expectations pinning lock position, error counts and clear behaviour.
module tb_lfsr_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bit_valid;
   logic        bit_in;
   logic        clear;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_count;
`ifdef LFSR_CHK_LOCKUP_DET_EN
   logic        lockup;
   localparam bit LockupEn = 1'b1;
`else
   localparam bit LockupEn = 1'b0;
`endif

   localparam int LockCnt = 16;
   localparam int LossCnt = 4;

   always #5 clk = ~clk;

   lfsr_checker #(
      .NUM_BITS (8),
      .LOCK_CNT (LockCnt),
      .LOSS_CNT (LossCnt),
      .CNT_W    (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_valid (bit_valid),
      .bit_in    (bit_in),
      .clear     (clear),
      .locked    (locked),
      .err_pulse (err_pulse),
`ifdef LFSR_CHK_LOCKUP_DET_EN
      .lockup    (lockup),
`endif
      .err_count (err_count)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // hist holds the last 8 register bits, oldest first: hist[8-k] is r[k].
   int m_mode;  // 0 hunt, 1 verify, 2 locked
   int m_fill, m_match, m_miss, m_cnt;
   bit m_pulse, m_lockup;
   int hist[$];

   function automatic int m_pred();
      return 1 - ((hist[0] + hist[2] + hist[3] + hist[4]) % 2);
   endfunction

   function automatic bit m_all_ones();
      int s = 0;
      foreach (hist[i]) s += hist[i];
      return s == 8;
   endfunction

   task automatic m_push(input int x);
      hist.push_back(x);
      void'(hist.pop_front());
   endtask

   task automatic m_reset();
      m_mode = 0; m_fill = 0; m_match = 0; m_miss = 0; m_cnt = 0;
      m_pulse = 0; m_lockup = 0;
      hist = {0, 0, 0, 0, 0, 0, 0, 0};
   endtask

   task automatic m_step(input bit v, input bit b, input bit c);
      int p;
      int om;
      m_pulse = 0;
      if (c) begin
         m_cnt = 0; m_mode = 0; m_fill = 0; m_match = 0; m_miss = 0; m_lockup = 0;
         return;
      end
      if (!v) return;
      p  = m_pred();
      om = m_mode;
      case (m_mode)
         0: begin
            m_push(int'(b));
            m_fill++;
            if (m_fill == 8) begin m_mode = 1; m_match = 0; end
         end
         1: begin
            m_push(int'(b));
            if (int'(b) == p) m_match++; else m_match = 0;
            if (m_match == LockCnt) begin m_mode = 2; m_miss = 0; end
         end
         default: begin
            m_push(p);
            if (int'(b) != p) begin
               m_pulse = 1;
               if (m_cnt < 65535) m_cnt++;
               m_miss++;
               if (m_miss == LossCnt) begin m_mode = 0; m_fill = 0; m_miss = 0; end
            end else begin
               m_miss = 0;
            end
         end
      endcase
      if (LockupEn && (om != 0 || m_mode != 0) && m_all_ones()) begin
         m_mode = 0; m_fill = 0; m_match = 0; m_miss = 0; m_lockup = 1;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_reset();
      else        m_step(bit_valid, bit_in, clear);
   end

   // Per-cycle compare, away from the active edge.
   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         check("locked", longint'(locked), longint'(m_mode == 2));
         check("err_pulse", longint'(err_pulse), longint'(m_pulse));
         check("err_count", longint'(err_count), longint'(m_cnt));
`ifdef LFSR_CHK_LOCKUP_DET_EN
         check("lockup", longint'(lockup), longint'(m_lockup));
`endif
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] g;

   task automatic gen_next(output bit b);
      b = ~(g[7] ^ g[5] ^ g[4] ^ g[3]);
      g = {g[6:0], b};
   endtask

   task automatic send(input bit v, input bit b, input bit c);
      bit_valid = v;
      bit_in    = b;
      clear     = c;
      @(negedge clk);
   endtask

   // Feeds good generator bits until lock, bounded; returns bits used (0 = no lock).
   task automatic run_to_lock(output int n);
      bit b;
      n = 0;
      for (int i = 1; i <= 60; i++) begin
         gen_next(b);
         send(1'b1, b, 1'b0);
         if (locked) begin n = i; break; end
      end
   endtask

   initial begin
      bit         b;
      bit         v;
      bit         c;
      bit         flip;
      bit         lost;
      int         lock_at;
      int         pulses;
      int         accepted;
      int         burst;
      logic [4:0] first5;

      rst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_locked", longint'(locked), 0);
      check("reset_err_pulse", longint'(err_pulse), 0);
      check("reset_err_count", longint'(err_count), 0);
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      // T1: clean stream from seed 0.
      g = 8'h00; lock_at = 0; first5 = '0;
      for (int i = 1; i <= 1000; i++) begin
         gen_next(b);
         if (i <= 5) first5 = {first5[3:0], b};
         send(1'b1, b, 1'b0);
         if (locked && lock_at == 0) lock_at = i;
      end
      check("t1_first_bits", longint'(first5), 5'b11110);
      check("t1_lock_at", lock_at, 24);
      check("t1_err_count", longint'(err_count), 0);

      // T2: single flipped bit while locked.
      pulses = 0; lost = 0;
      for (int i = 1; i <= 300; i++) begin
         gen_next(b);
         send(1'b1, b ^ (i == 100), 1'b0);
         if (err_pulse) pulses++;
         if (!locked) lost = 1;
      end
      check("t2_pulses", pulses, 1);
      check("t2_err_count", longint'(err_count), 1);
      check("t2_lost", longint'(lost), 0);

      // T3: four consecutive inverted bits drop lock; relock without clear.
      send(1'b0, 1'b0, 1'b1);
      run_to_lock(lock_at);
      check("t3_initial_lock", lock_at, 24);
      for (int k = 1; k <= 4; k++) begin
         gen_next(b);
         send(1'b1, ~b, 1'b0);
         if (k == 3) check("t3_locked_after_3", longint'(locked), 1);
      end
      check("t3_locked_after_4", longint'(locked), 0);
      check("t3_err_count", longint'(err_count), 4);
      run_to_lock(lock_at);
      check("t3_relock", lock_at, 24);

      // T4: 50% gaps on bit_valid.
      send(1'b0, 1'b0, 1'b1);
      accepted = 0; lock_at = 0;
      for (int i = 0; i < 300; i++) begin
         v = 1'($urandom_range(0, 1));
         if (v) begin gen_next(b); accepted++; end
         else b = 1'($urandom);
         send(v, b, 1'b0);
         if (locked && lock_at == 0) lock_at = accepted;
      end
      check("t4_lock_at", lock_at, 24);
      check("t4_err_count", longint'(err_count), 0);

      // T5: clear with a coincident bit while locked, err_count=7.
      for (int e = 0; e < 7; e++) begin
         gen_next(b);
         send(1'b1, ~b, 1'b0);
         repeat (3) begin gen_next(b); send(1'b1, b, 1'b0); end
      end
      check("t5_err_count_pre", longint'(err_count), 7);
      check("t5_locked_pre", longint'(locked), 1);
      send(1'b1, 1'($urandom), 1'b1);
      check("t5_err_count_post", longint'(err_count), 0);
      check("t5_locked_post", longint'(locked), 0);
      run_to_lock(lock_at);
      check("t5_relock", lock_at, 24);

      // T6: constant-1 stream.
      send(1'b0, 1'b0, 1'b1);
      lock_at = 0; lost = 0; accepted = 0;
      for (int i = 1; i <= 40; i++) begin
         send(1'b1, 1'b1, 1'b0);
         if (locked && lock_at == 0) lock_at = i;
`ifdef LFSR_CHK_LOCKUP_DET_EN
         if (lockup && accepted == 0) accepted = i;
`endif
      end
`ifdef LFSR_CHK_LOCKUP_DET_EN
      check("t6_lockup_at", accepted, 8);
      check("t6_never_locked", lock_at, 0);
`else
      check("t6_lock_at", lock_at, 24);
      check("t6_err_count", longint'(err_count), 0);
`endif

      // Randomized soak: gaps, isolated flips, loss bursts, stray clears.
      send(1'b0, 1'b0, 1'b1);
      g = 8'($urandom_range(0, 254));
      burst = 0;
      for (int i = 0; i < 4000; i++) begin
         v = ($urandom_range(0, 99) < 70);
         c = ($urandom_range(0, 999) < 3);
         if (burst == 0 && $urandom_range(0, 299) == 0) burst = 5;
         flip = (burst > 0) || ($urandom_range(0, 99) < 3);
         if (v) begin
            gen_next(b);
            if (burst > 0) burst--;
         end else begin
            b = 1'($urandom);
         end
         send(v, b ^ flip, c);
      end

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
